smem_result_writer: RTL and testbench
=====================================

// Module: smem_result_writer
// PURPOSE
//  Downstream consumer of the SMEM curr/mem result store's output port. After a start
//  pulse it waits for output_request and grants output_permit. It captures each 512-bit
//  result line into a FIFO and backpressures the whole pipeline through stall_out. It
//  drains lines to the host write channel at sequential line addresses, then pulses done.
// PARAMETERS
//  FIFO_DEPTH   16      result-line FIFO entries (power of 2, >=4)
//  ADDR_WIDTH   58      host line-address width (64-byte lines)
//  CNT_WIDTH    16      line counter width
//  MAX_LINES    16'hFFFF  lines accepted per run; excess lines dropped, flagged
// PORTS
//  clk            in   1    clock
//  reset_n        in   1    async active-low reset
//  start          in   1    one-cycle pulse; begin a run (ignored unless IDLE)
//  base_line      in   ADDR_WIDTH  first host line address, sampled on start
//  output_request in   1    result store has a batch ready
//  output_permit  out  1    grant to result store
//  output_valid   in   1    output_data holds a line
//  output_data    in   512  result line (header or two packed mem entries)
//  output_finish  in   1    result store has emitted all lines
//  stall_out      out  1    global pipeline stall (drives result store stall)
//  wr_valid       out  1    host write request valid
//  wr_addr        out  ADDR_WIDTH  host line address
//  wr_data        out  512  host write data
//  wr_ready       in   1    host accepts request when wr_valid&&wr_ready
//  busy           out  1    state != IDLE
//  done           out  1    one-cycle pulse at end of run
//  lines_written  out  CNT_WIDTH  lines accepted by host this run
//  overflow_err   out  1    sticky: a line was dropped (FIFO full or > MAX_LINES)
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE. All outputs 0 (output_permit, stall_out, wr_*,
//   busy, done, lines_written, overflow_err). FIFO empty, counters cleared.
//  FSM: IDLE -start-> ARM (latch base_line, clear lines_written/overflow_err);
//   ARM -output_request-> STREAM; STREAM -output_finish-> DRAIN;
//   DRAIN -(FIFO empty && !wr_valid)-> IDLE, with done=1 for exactly that cycle.
//  output_permit: registered, 1 in STREAM and DRAIN, 0 otherwise.
//  Capture: push output_data when output_valid && !stall_out && state==STREAM.
//   Upstream holds its outputs while stalled. A value seen under stall is re-presented
//   and captured after release, never twice. Valid gaps between read groups are skipped.
//  stall_out: registered = (next FIFO count >= FIFO_DEPTH-1). A capture therefore occurs
//   only when the count <= DEPTH-2 and can never overflow. stall_out=0 in IDLE/ARM.
//   Push on a full FIFO (protocol error): data dropped, overflow_err set.
//  Drain: wr_valid/wr_data come from the FIFO head, registered. wr_data/wr_addr stay
//   stable while wr_valid && !wr_ready. A new head is loaded the cycle after a handshake.
//   Min latency from capture to wr_valid: 2 cycles.
//  Simultaneous push and pop: count unchanged; a full FIFO with a pop that cycle still
//   refuses the push (stall_out already high).
//  Addressing: wr_addr = base_line + lines_written (ADDR_WIDTH modular add, no saturation).
//   lines_written += 1 per handshake.
//  Line limit: once MAX_LINES lines have been captured, further captures are dropped and
//   overflow_err is set; the run still completes on output_finish.
//  output_finish while FIFO non-empty: stay in DRAIN until empty. Valid in the same cycle
//   as finish: captured first.
//  start while busy: ignored. A reset mid-run clears everything; a FIFO line not yet
//   handshaked is lost, and upstream must also be reset.
// TESTING
//  1 reset, start(base_line=0x100), request, 5 valid lines D0..D4, wr_ready=1, finish
//    -> wr_addr 0x100..0x104 carry D0..D4 in order, lines_written=5, done one pulse, busy=0.
//  2 wr_ready=0 while 20 lines offered (DEPTH=16) -> stall_out high by count 15, no line
//    lost or duplicated; release wr_ready -> all 20 lines out in order.
//  3 Valid pattern 1,1,0,1 (group gap) plus stall during the held line -> exactly 3
//    captures, held line written once.
//  4 Random wr_ready (50%) -> wr_data/wr_addr stable while wr_valid&&!wr_ready.
//  5 MAX_LINES=3, 5 lines offered -> 3 written, overflow_err=1, done still pulses.
//  6 reset_n low mid-STREAM with 4 lines queued -> all outputs 0 immediately, IDLE;
//    start re-runs cleanly.

Source files
------------

// File: rtl/smem_result_writer_if.sv
// Bundles the result-store port, the host write channel and the run control
// of smem_result_writer. The slave modport is the writer; the master modport
// is its environment (result store, host, run controller).
interface smem_result_writer_if #(
  parameter int unsigned ADDR_WIDTH = 58,
  parameter int unsigned CNT_WIDTH  = 16
);
  // run control
  logic                  start;
  logic [ADDR_WIDTH-1:0] base_line;
  logic                  busy;
  logic                  done;
  logic [CNT_WIDTH-1:0]  lines_written;
  logic                  overflow_err;

  // result store output port
  logic                  output_request;
  logic                  output_permit;
  logic                  output_valid;
  logic [511:0]          output_data;
  logic                  output_finish;
  logic                  stall_out;

  // host write channel
  logic                  wr_valid;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [511:0]          wr_data;
  logic                  wr_ready;

  modport slave (
    input  start, base_line,
    input  output_request, output_valid, output_data, output_finish,
    input  wr_ready,
    output output_permit, stall_out,
    output wr_valid, wr_addr, wr_data,
    output busy, done, lines_written, overflow_err
  );

  modport master (
    output start, base_line,
    output output_request, output_valid, output_data, output_finish,
    output wr_ready,
    input  output_permit, stall_out,
    input  wr_valid, wr_addr, wr_data,
    input  busy, done, lines_written, overflow_err
  );
endinterface

// File: rtl/smem_result_writer.sv
// Consumes result lines from the SMEM result store, buffers them in a small
// FIFO (back-pressuring the whole pipeline through stall_out) and writes them
// to the host at consecutive 64-byte line addresses starting at base_line.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting for start
// S_ARM    | run armed, waiting for the result store to request output
// S_STREAM | permit granted, capturing lines until output_finish
// S_DRAIN  | no more captures; emptying FIFO and host register, then done
module smem_result_writer #(
  parameter int unsigned          FIFO_DEPTH = 16,
  parameter int unsigned          ADDR_WIDTH = 58,
  parameter int unsigned          CNT_WIDTH  = 16,
  parameter logic [CNT_WIDTH-1:0] MAX_LINES  = {CNT_WIDTH{1'b1}}
) (
  input logic                 clk,
  input logic                 reset_n,
  smem_result_writer_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);
  // stall one entry early: stall_out is registered, so one more capture can land
  localparam logic [CNT_W-1:0] STALL_CNT = CNT_W'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARM    = 2'd1,
    S_STREAM = 2'd2,
    S_DRAIN  = 2'd3
  } state_t;

  state_t                r_state;
  logic                  r_permit;
  logic                  r_stall;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_overflow;
  logic [CNT_WIDTH-1:0]  r_lines_written;
  logic [CNT_WIDTH-1:0]  r_captured;
  logic [ADDR_WIDTH-1:0] r_load_addr;

  logic [511:0]          r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;

  logic                  r_wr_valid;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [511:0]          r_wr_data;

  logic                  w_cap_try;
  logic                  w_at_limit;
  logic                  w_full;
  logic                  w_push;
  logic                  w_drop;
  logic                  w_hs;
  logic                  w_pop;
  logic                  w_drain_done;
  logic [CNT_W-1:0]      w_count_nxt;

  // Capture / drop / drain qualifiers for this cycle.
  always_comb begin
    w_cap_try    = bus.output_valid && !r_stall && (r_state == S_STREAM);
    w_at_limit   = (r_captured >= MAX_LINES);
    w_full       = (r_count == FULL_CNT);
    w_push       = w_cap_try && !w_full && !w_at_limit;
    w_drop       = w_cap_try && (w_full || w_at_limit);
    w_hs         = r_wr_valid && bus.wr_ready;
    // refill the host register when it is empty or being accepted this cycle
    w_pop        = (r_count != '0) && (!r_wr_valid || w_hs);
    w_drain_done = (r_state == S_DRAIN) && (r_count == '0) && !r_wr_valid;
  end

  // Occupancy after this cycle's push/pop; also drives the registered stall.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  // Run sequencing with registered permit, stall, busy and done.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_permit <= 1'b0;
      r_stall  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_stall <= ((r_state == S_STREAM) || (r_state == S_DRAIN)) &&
                 (w_count_nxt >= STALL_CNT);
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state <= S_ARM;
            r_busy  <= 1'b1;
          end
        end
        S_ARM: begin
          if (bus.output_request) begin
            r_state  <= S_STREAM;
            r_permit <= 1'b1;
          end
        end
        S_STREAM: begin
          // a line valid alongside finish is still captured this cycle
          if (bus.output_finish) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (w_drain_done) begin
            r_state  <= S_IDLE;
            r_permit <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_permit <= 1'b0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  // Per-run bookkeeping: line limit, sticky overflow, host counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_load_addr     <= '0;
      r_lines_written <= '0;
      r_captured      <= '0;
      r_overflow      <= 1'b0;
    end else if ((r_state == S_IDLE) && bus.start) begin
      r_load_addr     <= bus.base_line;
      r_lines_written <= '0;
      r_captured      <= '0;
      r_overflow      <= 1'b0;
    end else begin
      if (w_push) r_captured      <= r_captured + 1'b1;
      if (w_drop) r_overflow      <= 1'b1;
      if (w_hs)   r_lines_written <= r_lines_written + 1'b1;
      // lines leave the FIFO in order, so the n-th load gets base + n
      if (w_pop)  r_load_addr     <= r_load_addr + 1'b1;
    end
  end

  // FIFO storage; contents need no reset since occupancy is tracked separately.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.output_data;
  end

  // FIFO pointers and the registered host write request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_wr_valid <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
      if (w_pop) begin
        r_wr_valid <= 1'b1;
        r_wr_data  <= r_mem[r_rd_ptr];
        r_wr_addr  <= r_load_addr;
      end else if (w_hs) begin
        r_wr_valid <= 1'b0;
      end
    end
  end

  assign bus.output_permit = r_permit;
  assign bus.stall_out     = r_stall;
  assign bus.wr_valid      = r_wr_valid;
  assign bus.wr_addr       = r_wr_addr;
  assign bus.wr_data       = r_wr_data;
  assign bus.busy          = r_busy;
  assign bus.done          = r_done;
  assign bus.lines_written = r_lines_written;
  assign bus.overflow_err  = r_overflow;

endmodule

// File: tb/tb_smem_result_writer.sv
// Bench for smem_result_writer: an upstream model offers random lines and
// honours stall_out; every line the writer takes is turned into an expected
// host write (base + accept index, unless past the line limit) and queued;
// an independent monitor pops and compares on every host handshake.
module tb_smem_result_writer;
  localparam int unsigned          DEPTH = 16;
  localparam int unsigned          AW    = 58;
  localparam int unsigned          CW    = 16;
  localparam logic [CW-1:0]        MAXL  = 16'd24;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  smem_result_writer_if #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

  smem_result_writer #(
    .FIFO_DEPTH(DEPTH),
    .ADDR_WIDTH(AW),
    .CNT_WIDTH (CW),
    .MAX_LINES (MAXL)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [511:0]  d;
  } exp_t;

  exp_t          exp_q[$];
  int            run_cnt;
  logic          exp_ovf;
  logic [AW-1:0] cur_base;
  int            n_checks = 0;
  int            n_pass   = 0;
  int            ready_mode = 1;   // 0 low, 1 high, 2 random

  logic          mon_hold;
  logic [AW-1:0] mon_a;
  logic [511:0]  mon_d;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [511:0] rand_line();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Host ready driver.
  initial begin
    bus.wr_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       bus.wr_ready = 1'b0;
        1:       bus.wr_ready = 1'b1;
        default: bus.wr_ready = ($urandom_range(0, 1) == 1);
      endcase
    end
  end

  // Scoreboard monitor: every handshake must match the oldest expected line,
  // and a pending request must hold still until accepted.
  initial begin
    exp_t e;
    mon_hold = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        mon_hold = 1'b0;
      end else begin
        if (mon_hold) begin
          chk("hold_valid", bus.wr_valid, 1'b1);
          chk("hold_addr", bus.wr_addr, mon_a);
          chk("hold_data", bus.wr_data, mon_d);
        end
        if (bus.wr_valid && bus.wr_ready) begin
          chk("write_expected", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("wr_addr", bus.wr_addr, e.a);
            chk("wr_data", bus.wr_data, e.d);
          end
        end
        mon_hold = bus.wr_valid && !bus.wr_ready;
        mon_a    = bus.wr_addr;
        mon_d    = bus.wr_data;
      end
    end
  end

  // Reference model: a taken line is the run_cnt-th of the run.
  task automatic accept(input logic [511:0] d);
    exp_t e;
    if (run_cnt < int'(MAXL)) begin
      e.a = cur_base + AW'(run_cnt);
      e.d = d;
      exp_q.push_back(e);
    end else begin
      exp_ovf = 1'b1;
    end
    run_cnt++;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_permit"}, bus.output_permit, 1'b0);
    chk({tag, "_stall"}, bus.stall_out, 1'b0);
    chk({tag, "_wr_valid"}, bus.wr_valid, 1'b0);
    chk({tag, "_wr_addr"}, bus.wr_addr, '0);
    chk({tag, "_wr_data"}, bus.wr_data, '0);
    chk({tag, "_busy"}, bus.busy, 1'b0);
    chk({tag, "_done"}, bus.done, 1'b0);
    chk({tag, "_lines"}, bus.lines_written, '0);
    chk({tag, "_ovf"}, bus.overflow_err, 1'b0);
  endtask

  task automatic start_run(input logic [AW-1:0] base);
    bit got;
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.base_line = base;
    cur_base = base;
    run_cnt  = 0;
    exp_ovf  = 1'b0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.output_request = 1'b1;
    @(negedge clk);
    chk("busy_after_start", bus.busy, 1'b1);
    chk("permit_in_arm", bus.output_permit, 1'b0);
    got = 0;
    for (int k = 0; k < 50 && !got; k++) begin
      if (bus.output_permit) got = 1;
      else @(negedge clk);
    end
    chk("permit_granted", got, 1'b1);
    @(posedge clk);
    #1;
    bus.output_request = 1'b0;
  endtask

  // Upstream model: present a line and hold it until a cycle without stall.
  task automatic offer_line(input logic [511:0] d, input bit fin);
    bit tk;
    tk = 0;
    bus.output_valid  = 1'b1;
    bus.output_data   = d;
    bus.output_finish = fin;
    for (int k = 0; k < 500 && !tk; k++) begin
      @(negedge clk);
      tk = bus.output_permit && !bus.stall_out;
      @(posedge clk);
      #1;
    end
    bus.output_valid  = 1'b0;
    bus.output_finish = 1'b0;
    if (tk) accept(d);
    else chk("line_taken", tk, 1'b1);
  endtask

  task automatic gap();
    bus.output_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input int n, input int gap_pct);
    for (int i = 0; i < n; i++) begin
      if (int'($urandom_range(0, 99)) < gap_pct) gap();
      offer_line(rand_line(), 1'b0);
    end
  endtask

  task automatic finish_run(input bit fin_sent);
    bit got;
    int exp_wr;
    if (!fin_sent) begin
      bus.output_finish = 1'b1;
      @(posedge clk);
      #1;
      bus.output_finish = 1'b0;
    end
    got = 0;
    for (int k = 0; k < 3000 && !got; k++) begin
      @(negedge clk);
      if (bus.done) got = 1;
    end
    chk("done_seen", got, 1'b1);
    exp_wr = (run_cnt < int'(MAXL)) ? run_cnt : int'(MAXL);
    chk("lines_written", bus.lines_written, CW'(exp_wr));
    chk("overflow_err", bus.overflow_err, exp_ovf);
    chk("busy_at_done", bus.busy, 1'b0);
    chk("all_lines_out", exp_q.size(), 0);
    @(negedge clk);
    chk("done_one_cycle", bus.done, 1'b0);
    chk("permit_idle", bus.output_permit, 1'b0);
  endtask

  initial begin
    logic [AW-1:0] wrap_base;
    bus.start          = 1'b0;
    bus.base_line      = '0;
    bus.output_request = 1'b0;
    bus.output_valid   = 1'b0;
    bus.output_data    = '0;
    bus.output_finish  = 1'b0;
    run_cnt  = 0;
    exp_ovf  = 1'b0;
    cur_base = '0;

    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // 1: five lines, last one alongside finish; a start mid-run is ignored
    ready_mode = 1;
    start_run(58'h100);
    offer_line(rand_line(), 1'b0);
    offer_line(rand_line(), 1'b0);
    bus.start = 1'b1;
    bus.base_line = 58'h999;
    offer_line(rand_line(), 1'b0);
    bus.start = 1'b0;
    offer_line(rand_line(), 1'b0);
    offer_line(rand_line(), 1'b1);
    finish_run(1'b1);

    // 2: host blocked while 20 lines are offered
    ready_mode = 0;
    start_run(58'h2000);
    fork
      offer(20, 0);
      begin
        repeat (60) @(negedge clk);
        chk("t2_stall_high", bus.stall_out, 1'b1);
        chk("t2_taken_before_release", run_cnt, DEPTH);
        @(posedge clk);
        #1;
        ready_mode = 1;
      end
    join
    finish_run(1'b0);

    // 3: group pattern 1,1,0,1 with the second line held under stall
    ready_mode = 0;
    start_run(58'h3000);
    fork
      begin
        offer(DEPTH - 1, 0);
        offer_line(rand_line(), 1'b0);
        offer_line(rand_line(), 1'b0);
        gap();
        offer_line(rand_line(), 1'b0);
      end
      begin
        repeat (50) @(negedge clk);
        chk("t3_stall_high", bus.stall_out, 1'b1);
        chk("t3_taken_before_release", run_cnt, DEPTH);
        @(posedge clk);
        #1;
        ready_mode = 1;
      end
    join
    finish_run(1'b0);

    // 4: random host ready and valid gaps, address wraps past the top
    ready_mode = 2;
    wrap_base = '1;
    wrap_base = wrap_base - 2;
    start_run(wrap_base);
    offer(30, 30);
    finish_run(1'b0);

    // 5: more lines than the line limit
    ready_mode = 1;
    start_run(58'h5000);
    offer(int'(MAXL) + 4, 10);
    finish_run(1'b0);

    // 6: reset mid-stream with lines queued, then a clean rerun
    ready_mode = 0;
    start_run(58'h40);
    offer(5, 0);
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_zero("midrun_reset");
    exp_q.delete();
    bus.output_valid  = 1'b0;
    bus.output_finish = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    ready_mode = 1;
    start_run(58'h300);
    offer(6, 20);
    finish_run(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
